// File: rtl/seg7_scan_driver_if.sv
// Capture/display bundle for seg7_scan_driver: producer-side inputs and scanned display outputs.
interface seg7_scan_driver_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [6:0]  seg7;
  logic        dp_n;
  logic [3:0]  select;
  logic        frame_tick;
  logic        pending;

  modport master (
    output value, load, dp_in,
    input  seg7, dp_n, select, frame_tick, pending
  );

  modport slave (
    input  value, load, dp_in,
    output seg7, dp_n, select, frame_tick, pending
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode hex scanner with blanking gaps and frame-boundary (tear-free) commit.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits.
//
// state | meaning
// BLANK | all anodes off for BLANK_CYCLES; on exit advance digit (wrap 3->0 = commit)
// SHOW  | current digit driven for REFRESH_DIV cycles
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_driver_if.slave  bus
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          started;
  logic [15:0]   stage_val;
  logic [15:0]   shadow_val;
  logic [3:0]    stage_dp;
  logic [3:0]    shadow_dp;

  logic       show_done;
  logic       blank_done;
  logic       wrap;
  logic [3:0] cur_nib;
  logic       lz;

  assign show_done  = (state == SHOW)  && (cnt == SHOW_LAST);
  assign blank_done = (state == BLANK) && (cnt == BLANK_LAST);
  // The BLANK exit right after reset starts digit 0 rather than advancing, so it is not a wrap.
  assign wrap       = blank_done && started && (idx == 2'd3);
  assign cur_nib    = shadow_val[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz = 1'b0;
    case (idx)
      2'd3:    lz = (shadow_val[15:12] == 4'h0)  && !shadow_dp[3];
      2'd2:    lz = (shadow_val[15:8]  == 8'h00) && !shadow_dp[2];
      2'd1:    lz = (shadow_val[15:4]  == 12'h0) && !shadow_dp[1];
      default: lz = 1'b0;
    endcase
  end
`else
  assign lz = 1'b0;
`endif

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= BLANK;
      cnt            <= '0;
      idx            <= 2'd0;
      started        <= 1'b0;
      stage_val      <= 16'h0;
      stage_dp       <= 4'h0;
      shadow_val     <= 16'h0;
      shadow_dp      <= 4'h0;
      bus.pending    <= 1'b0;
      bus.frame_tick <= 1'b0;
      bus.seg7       <= 7'h7F;
      bus.dp_n       <= 1'b1;
      bus.select     <= 4'hF;
    end else begin
      bus.frame_tick <= wrap;

      if (bus.load) begin
        stage_val   <= bus.value;
        stage_dp    <= bus.dp_in;
        bus.pending <= 1'b1;
      end
      // A load on the commit edge bypasses staging; the later pending write wins.
      if (wrap && (bus.pending || bus.load)) begin
        shadow_val  <= bus.load ? bus.value : stage_val;
        shadow_dp   <= bus.load ? bus.dp_in : stage_dp;
        bus.pending <= 1'b0;
      end

      case (state)
        SHOW: begin
          if (show_done) begin
            state <= BLANK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (blank_done) begin
            state   <= SHOW;
            cnt     <= '0;
            started <= 1'b1;
            if (started) idx <= idx + 2'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase

      if (state == SHOW) begin
        bus.select <= ~(4'b0001 << idx);
        bus.seg7   <= lz ? 7'h7F : hex_seg(cur_nib);
        bus.dp_n   <= ~shadow_dp[idx];
      end else begin
        bus.select <= 4'hF;
        bus.seg7   <= 7'h7F;
        bus.dp_n   <= 1'b1;
      end
    end
  end

endmodule
